stack_engine: RTL and testbench
===============================

Name: stack_engine

Overview:
- Memory-stage responder for the stack requests that the decode-stage control unit issues during PUSH, POP, CALL, RET, RETI and interrupt entry.
- Owns the stack pointer and drives the 16-bit data-memory port for stack accesses.
- Splits the 32-bit PC into two 16-bit words on push, and reassembles PC, flags and register values on pop.
- Flags overflow, underflow and mis-ordered PC restores.

Parameters:
- ADDR_W, 12, data-memory word-address width.
- SP_TOP, 2**12-1, reset/empty stack pointer value (first push lands here).
- DEPTH, 64, maximum number of stacked words.
- FLAG_W, 3, flag register width (Z,N,C).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- push_req  in  1  push one word this cycle.
- pop_req  in  1  pop one word this cycle.
- src_sel  in  2  word kind: 00 flags, 01 PC high, 10 PC low, 11 register.
- reg_wdata  in  16  register value for src_sel=11 push.
- flags_in  in  FLAG_W  flags for src_sel=00 push.
- pc_in  in  32  PC for src_sel=01/10 push.
- mem_addr  out  ADDR_W  data-memory address.
- mem_wdata  out  16  data-memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_rdata  in  16  memory read data; synchronous, valid the cycle after mem_re.
- reg_pop_valid  out  1  reg_pop_data valid.
- reg_pop_data  out  16  popped register value.
- flags_restore_valid  out  1  flags_restore valid.
- flags_restore  out  FLAG_W  popped flags (mem_rdata[FLAG_W-1:0]).
- pc_restore_valid  out  1  pc_restore valid.
- pc_restore  out  32  reassembled PC {high,low}.
- sp  out  ADDR_W  current stack pointer.
- overflow  out  1  sticky: push refused because full.
- underflow  out  1  sticky: pop refused because empty.
- seq_err  out  1  sticky: PC high popped without a preceding PC low.

Behaviour:
- Reset (async, active-high):
  - sp=SP_TOP.
  - All valids, mem_we, mem_re and sticky flags = 0.
  - pc_restore=0, low buffer=0, PC FSM = PC_IDLE.
- Empty: sp==SP_TOP. Full: sp==SP_TOP-DEPTH.
- Push (accepted when not full), all in the same cycle, combinational from inputs:
  - mem_we=1, mem_addr=sp.
  - mem_wdata = flags zero-extended / pc_in[31:16] / pc_in[15:0] / reg_wdata, per src_sel.
  - sp <= sp-1 at the clock edge.
- Pop (accepted when not empty):
  - mem_re=1, mem_addr=sp+1; sp <= sp+1.
  - A registered tag holds the src_sel of the pop; routing happens in the following cycle from mem_rdata.
  - Pop latency: request in cycle N, the selected *_valid is high for exactly cycle N+1.
  - Register and flags data are combinational from mem_rdata in cycle N+1.
- Refused push while full: no memory access, sp unchanged, overflow<=1.
- Refused pop while empty: no memory access, sp unchanged, underflow<=1, no valid pulse.
- push_req and pop_req together: push wins; the pop is dropped and seq_err<=1.
- Idle cycles: mem_addr=sp, mem_wdata=0.
- PC reassembly FSM, states PC_IDLE and PC_HAVE_LOW:
  - PC-low tag return: latch low buffer from mem_rdata, go to PC_HAVE_LOW.
  - PC-high tag return in PC_HAVE_LOW: pc_restore <= {mem_rdata, low}, registered. pc_restore_valid pulses in cycle N+2; go to PC_IDLE.
  - PC-high tag return in PC_IDLE: still emits {mem_rdata, low buffer} and sets seq_err.
  - PC-low return in PC_HAVE_LOW: overwrites the low buffer.
- Push order: RETI/RET expects pushes in the order PC high, PC low, flags. Pops therefore arrive in the order flags, PC low, PC high.
- A push or pop in the cycle a previous pop's data returns is legal (full throughput, one op per cycle).
- Reset mid-sequence abandons all pending returns; no valid pulses after reset.
- Sticky flags clear only on reset.
- sp arithmetic is modulo 2^ADDR_W, but full/empty checks prevent wrap in legal use.

Decomposition:
- Shared package stack_pkg holds:
  - src_sel encoding enum (SRC_FLAGS, SRC_PC_HI, SRC_PC_LO, SRC_REG).
  - PC FSM state enum (PC_IDLE, PC_HAVE_LOW).
- One sub-module, stack_pointer_ctrl: holds sp, computes full/empty, and grants push/pop.
- stack_engine keeps the datapath muxing, the return tag and the PC FSM.

Test Plan:
- Push reg 0x1234, then pop reg → push writes addr 0xFFF with data 0x1234; pop reads 0xFFF; reg_pop_valid=1 with 0x1234 one cycle after the pop; sp back to 0xFFF.
- Interrupt sequence: push PC high, PC low, flags with pc_in=0x0001_00A4, flags=3'b101. Then pop flags, PC low, PC high. Required:
  - Writes at 0xFFF/0xFFE/0xFFD of 0x0001/0x00A4/0x0005.
  - flags_restore=3'b101.
  - pc_restore=0x000100A4 pulsed once.
  - sp=0xFFF.
- Pop from empty → no mem_re, underflow=1, sp=0xFFF, no valid.
- Perform 64 pushes, then a 65th push → the 65th has no mem_we and overflow=1; sp=0xFBF.
- Simultaneous push and pop with 2 words stacked → only the push happens; sp decrements by 1; seq_err=1.
- Pop PC high with no prior PC low → pc_restore_valid pulses with the low half from the buffer (0 after reset); seq_err=1.
- Assert reset between PC-low and PC-high pops → FSM returns to PC_IDLE; a later PC-high pop sets seq_err.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: shared encodings for the stack engine
package stack_pkg;
  typedef enum logic [1:0] {
    SRC_FLAGS = 2'b00,
    SRC_PC_HI = 2'b01,
    SRC_PC_LO = 2'b10,
    SRC_REG   = 2'b11
  } src_sel_e;
  typedef enum logic {
    PC_IDLE,
    PC_HAVE_LOW
  } pc_state_e;
endpackage

// File: rtl/stack_pointer_ctrl.sv
// stack_pointer_ctrl: owns sp, reports full/empty and grants push/pop (push wins)
// Ports: clk, reset, push_req, pop_req in; sp, full, empty, push_ok, pop_ok out.
module stack_pointer_ctrl #(
  parameter int ADDR_W = 12,
  parameter int SP_TOP = 2**ADDR_W-1,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_req,
  input  logic              pop_req,
  output logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              empty,
  output logic              push_ok,
  output logic              pop_ok
);
  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(SP_TOP);
  localparam logic [ADDR_W-1:0] BOTTOM = ADDR_W'(SP_TOP - DEPTH);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  assign empty = sp == TOP;
  assign full = sp == BOTTOM;
  // grants are masked during reset so no memory access escapes while it is held
  assign push_ok = push_req & ~full & ~reset;
  assign pop_ok = pop_req & ~push_req & ~empty & ~reset;
  always_ff @(posedge clk or posedge reset)
    if (reset) sp <= TOP;
    else if (push_ok) sp <= sp - ONE;
    else if (pop_ok) sp <= sp + ONE;
endmodule

// File: rtl/stack_engine.sv
// stack_engine: memory-stage stack responder; pushes/pops words and rebuilds PC, flags and registers
// Ports: push_req/pop_req/src_sel/reg_wdata/flags_in/pc_in requests; mem_* data-memory port;
//        reg_pop_*, flags_restore*, pc_restore* results; sp; sticky overflow/underflow/seq_err.
module stack_engine
  import stack_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int SP_TOP = 2**12-1,
  parameter int DEPTH  = 64,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic [1:0]        src_sel,
  input  logic [15:0]       reg_wdata,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [31:0]       pc_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata,
  output logic              reg_pop_valid,
  output logic [15:0]       reg_pop_data,
  output logic              flags_restore_valid,
  output logic [FLAG_W-1:0] flags_restore,
  output logic              pc_restore_valid,
  output logic [31:0]       pc_restore,
  output logic [ADDR_W-1:0] sp,
  output logic              overflow,
  output logic              underflow,
  output logic              seq_err
);
  src_sel_e  sel, rtn_sel;
  pc_state_e pc_state;
  logic full, empty, push_ok, pop_ok, rtn_valid;
  logic [15:0] push_word, low;
  assign sel = src_sel_e'(src_sel);
  stack_pointer_ctrl #(.ADDR_W(ADDR_W), .SP_TOP(SP_TOP), .DEPTH(DEPTH)) u_sp (
    .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req),
    .sp(sp), .full(full), .empty(empty), .push_ok(push_ok), .pop_ok(pop_ok)
  );
  always_comb
    push_word = sel == SRC_FLAGS ? 16'(flags_in) :
                sel == SRC_PC_HI ? pc_in[31:16] :
                sel == SRC_PC_LO ? pc_in[15:0] : reg_wdata;
  assign mem_we = push_ok;
  assign mem_re = pop_ok;
  // pops read the last written slot, one above the free slot sp points at
  assign mem_addr = pop_ok ? sp + ADDR_W'(1) : sp;
  assign mem_wdata = push_ok ? push_word : '0;
  assign reg_pop_valid = rtn_valid && rtn_sel == SRC_REG;
  assign reg_pop_data = mem_rdata;
  assign flags_restore_valid = rtn_valid && rtn_sel == SRC_FLAGS;
  assign flags_restore = mem_rdata[FLAG_W-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rtn_valid <= 1'b0;
      rtn_sel <= SRC_FLAGS;
      pc_state <= PC_IDLE;
      low <= '0;
      pc_restore <= '0;
      pc_restore_valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      rtn_valid <= pop_ok;
      if (pop_ok) rtn_sel <= sel;
      pc_restore_valid <= rtn_valid && rtn_sel == SRC_PC_HI;
      if (rtn_valid && rtn_sel == SRC_PC_LO) begin
        low <= mem_rdata;
        pc_state <= PC_HAVE_LOW;
      end
      // a high half with no low half pending still emits, using whatever low is buffered
      if (rtn_valid && rtn_sel == SRC_PC_HI) begin
        pc_restore <= {mem_rdata, low};
        pc_state <= PC_IDLE;
      end
      overflow <= overflow | (push_req & full);
      underflow <= underflow | (pop_req & ~push_req & empty);
      seq_err <= seq_err | (push_req & pop_req) |
                 (rtn_valid && rtn_sel == SRC_PC_HI && pc_state == PC_IDLE);
    end
endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: scoreboard bench for stack_engine with a synchronous memory model
module tb_stack_engine;
  import stack_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic push_req = 1'b0, pop_req = 1'b0;
  logic [1:0] src_sel = 2'b00;
  logic [15:0] reg_wdata = '0;
  logic [2:0] flags_in = '0;
  logic [31:0] pc_in = '0;
  logic [11:0] mem_addr, sp;
  logic [15:0] mem_wdata, mem_rdata, reg_pop_data;
  logic mem_we, mem_re, reg_pop_valid, flags_restore_valid, pc_restore_valid;
  logic overflow, underflow, seq_err;
  logic [2:0] flags_restore;
  logic [31:0] pc_restore;
  logic [15:0] mem [0:4095];
  int checks = 0, errors = 0, cyc = 0;
  logic [27:0] wq [$];
  logic [47:0] rq [$];
  stack_engine dut (
    .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req), .src_sel(src_sel),
    .reg_wdata(reg_wdata), .flags_in(flags_in), .pc_in(pc_in), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .reg_pop_valid(reg_pop_valid), .reg_pop_data(reg_pop_data),
    .flags_restore_valid(flags_restore_valid), .flags_restore(flags_restore),
    .pc_restore_valid(pc_restore_valid), .pc_restore(pc_restore), .sp(sp),
    .overflow(overflow), .underflow(underflow), .seq_err(seq_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end
  task automatic drive(input logic pu, input logic po, input logic [1:0] s);
    push_req = pu;
    pop_req = po;
    src_sel = s;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    drive(0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({sp, mem_we, mem_re, reg_pop_valid, flags_restore_valid, pc_restore_valid,
         overflow, underflow, seq_err, pc_restore} !== {12'hFFF, 8'h00, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: sp=%h we=%b re=%b v=%b%b%b sticky=%b%b%b pc=%h", sp, mem_we,
               mem_re, reg_pop_valid, flags_restore_valid, pc_restore_valid, overflow,
               underflow, seq_err, pc_restore);
    end
    tick();
  endtask
  task automatic test_push_pop_reg();
    logic [27:0] w;
    logic [47:0] r;
    reg_wdata = 16'h1234;
    drive(1, 0, SRC_REG);
    wq.push_back({12'hFFF, 16'h1234});
    @(negedge clk);
    w = wq.pop_front();
    checks++;
    if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== w) begin
      errors++;
      $display("FAIL reg_push_write: we=%b addr/data=%h expected %h", mem_we, {mem_addr, mem_wdata}, w);
    end
    tick();
    drive(0, 1, SRC_REG);
    rq.push_back({16'(cyc + 1), 32'h1234});
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'hFFF) begin
      errors++;
      $display("FAIL reg_pop_read: re=%b we=%b addr=%h expected 1 0 fff", mem_re, mem_we, mem_addr);
    end
    tick();
    drive(0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (reg_pop_valid) begin
        checks++;
        r = rq.size() != 0 ? rq.pop_front() : 48'hFFFF_DEADBEEF;
        if (r[47:32] !== 16'(cyc) || reg_pop_data !== r[15:0]) begin
          errors++;
          $display("FAIL reg_pop_data: cyc=%0d data=%h expected cyc=%0d data=%h", cyc, reg_pop_data, r[47:32], r[15:0]);
        end
      end
      tick();
    end
    checks++;
    if (rq.size() != 0 || sp !== 12'hFFF) begin
      errors++;
      $display("FAIL reg_pop_done: pending=%0d sp=%h expected 0 fff", rq.size(), sp);
      rq.delete();
    end
  endtask
  task automatic test_interrupt();
    logic [1:0] ps [3];
    logic [15:0] wd [3];
    logic [27:0] w;
    logic [47:0] r;
    ps = '{SRC_PC_HI, SRC_PC_LO, SRC_FLAGS};
    wd = '{16'h0001, 16'h00A4, 16'h0005};
    pc_in = 32'h0001_00A4;
    flags_in = 3'b101;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, ps[i]);
      wq.push_back({12'(12'hFFF - i), wd[i]});
      @(negedge clk);
      w = wq.pop_front();
      checks++;
      if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== w) begin
        errors++;
        $display("FAIL irq_push_%0d: we=%b addr/data=%h expected %h", i, mem_we, {mem_addr, mem_wdata}, w);
      end
      tick();
    end
    ps = '{SRC_FLAGS, SRC_PC_LO, SRC_PC_HI};
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(0, 1, ps[c]);
      else drive(0, 0, 0);
      if (c == 0) rq.push_back({16'(cyc + 1), 32'h5});
      if (c == 2) rq.push_back({16'(cyc + 2), 32'h0001_00A4});
      @(negedge clk);
      if (flags_restore_valid) begin
        checks++;
        r = rq.size() != 0 ? rq.pop_front() : 48'hFFFF_DEADBEEF;
        if (r[47:32] !== 16'(cyc) || 32'(flags_restore) !== r[31:0]) begin
          errors++;
          $display("FAIL irq_flags: cyc=%0d flags=%b expected cyc=%0d flags=%h", cyc, flags_restore, r[47:32], r[31:0]);
        end
      end
      if (pc_restore_valid) begin
        checks++;
        r = rq.size() != 0 ? rq.pop_front() : 48'hFFFF_DEADBEEF;
        if (r[47:32] !== 16'(cyc) || pc_restore !== r[31:0]) begin
          errors++;
          $display("FAIL irq_pc: cyc=%0d pc=%h expected cyc=%0d pc=%h", cyc, pc_restore, r[47:32], r[31:0]);
        end
      end
      tick();
    end
    checks++;
    if (rq.size() != 0 || sp !== 12'hFFF || seq_err !== 1'b0 || reg_pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL irq_done: pending=%0d sp=%h seq_err=%b expected 0 fff 0", rq.size(), sp, seq_err);
      rq.delete();
    end
  endtask
  task automatic test_underflow();
    drive(0, 1, SRC_REG);
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL underflow_access: re=%b we=%b expected 0 0", mem_re, mem_we);
    end
    tick();
    drive(0, 0, 0);
    @(negedge clk);
    checks++;
    if (underflow !== 1'b1 || sp !== 12'hFFF || reg_pop_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_state: uf=%b sp=%h valid=%b of=%b expected 1 fff 0 0", underflow, sp, reg_pop_valid, overflow);
    end
    tick();
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      reg_wdata = 16'(i);
      drive(1, 0, SRC_REG);
      tick();
    end
    checks++;
    if (sp !== 12'hFBF || overflow !== 1'b0 || mem[12'hFC0] !== 16'd63) begin
      errors++;
      $display("FAIL fill_64: sp=%h of=%b last=%h expected fbf 0 003f", sp, overflow, mem[12'hFC0]);
    end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL overflow_write: we=%b expected 0", mem_we);
    end
    tick();
    drive(0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || sp !== 12'hFBF) begin
      errors++;
      $display("FAIL overflow_state: of=%b sp=%h expected 1 fbf", overflow, sp);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      reg_wdata = 16'hA000 + 16'(i);
      drive(1, 0, SRC_REG);
      tick();
    end
    reg_wdata = 16'h5555;
    drive(1, 1, SRC_REG);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 12'hFFD || mem_wdata !== 16'h5555) begin
      errors++;
      $display("FAIL collide_access: we=%b re=%b addr=%h data=%h expected 1 0 ffd 5555", mem_we, mem_re, mem_addr, mem_wdata);
    end
    tick();
    drive(0, 0, 0);
    @(negedge clk);
    checks++;
    if (sp !== 12'hFFC || seq_err !== 1'b1 || reg_pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_state: sp=%h seq_err=%b valid=%b expected ffc 1 0", sp, seq_err, reg_pop_valid);
    end
    tick();
  endtask
  task automatic test_pc_hi_no_low();
    logic [47:0] r;
    do_reset();
    pc_in = 32'hBEEF_0000;
    drive(1, 0, SRC_PC_HI);
    tick();
    drive(0, 1, SRC_PC_HI);
    rq.push_back({16'(cyc + 2), 32'hBEEF_0000});
    for (int c = 0; c < 4; c++) begin
      if (c == 1) drive(0, 0, 0);
      @(negedge clk);
      if (pc_restore_valid) begin
        checks++;
        r = rq.size() != 0 ? rq.pop_front() : 48'hFFFF_DEADBEEF;
        if (r[47:32] !== 16'(cyc) || pc_restore !== r[31:0]) begin
          errors++;
          $display("FAIL orphan_pc: cyc=%0d pc=%h expected cyc=%0d pc=%h", cyc, pc_restore, r[47:32], r[31:0]);
        end
      end
      tick();
    end
    checks++;
    if (rq.size() != 0 || seq_err !== 1'b1) begin
      errors++;
      $display("FAIL orphan_seq: pending=%0d seq_err=%b expected 0 1", rq.size(), seq_err);
      rq.delete();
    end
  endtask
  task automatic test_reset_mid_seq();
    logic [47:0] r;
    do_reset();
    pc_in = 32'h1111_2222;
    drive(1, 0, SRC_PC_HI);
    tick();
    drive(1, 0, SRC_PC_LO);
    tick();
    drive(0, 1, SRC_PC_LO);
    tick();
    drive(0, 0, 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({reg_pop_valid, flags_restore_valid, pc_restore_valid, seq_err, mem_re} !== 5'b0 || sp !== 12'hFFF) begin
      errors++;
      $display("FAIL midseq_reset: valids=%b%b%b seq_err=%b re=%b sp=%h expected 00000 fff", reg_pop_valid,
               flags_restore_valid, pc_restore_valid, seq_err, mem_re, sp);
    end
    tick();
    reset = 1'b0;
    pc_in = 32'h3333_4444;
    drive(1, 0, SRC_PC_HI);
    tick();
    drive(0, 1, SRC_PC_HI);
    rq.push_back({16'(cyc + 2), 32'h3333_0000});
    for (int c = 0; c < 4; c++) begin
      if (c == 1) drive(0, 0, 0);
      @(negedge clk);
      if (pc_restore_valid) begin
        checks++;
        r = rq.size() != 0 ? rq.pop_front() : 48'hFFFF_DEADBEEF;
        if (r[47:32] !== 16'(cyc) || pc_restore !== r[31:0]) begin
          errors++;
          $display("FAIL midseq_pc: cyc=%0d pc=%h expected cyc=%0d pc=%h", cyc, pc_restore, r[47:32], r[31:0]);
        end
      end
      tick();
    end
    checks++;
    if (rq.size() != 0 || seq_err !== 1'b1) begin
      errors++;
      $display("FAIL midseq_seq: pending=%0d seq_err=%b expected 0 1", rq.size(), seq_err);
      rq.delete();
    end
  endtask
  initial begin
    test_reset();
    test_push_pop_reg();
    test_interrupt();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_pc_hi_no_low();
    test_reset_mid_seq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
